// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage.
//   XLEN_DEF / ILEN_DEF : default PC and instruction widths
//   RESET_PC_DEF        : PC loaded on reset
//   NOP_INSTR           : canonical NOP (addi x0, x0, 0)
//   fetch_entry_t       : {pc, instr} pair as held in the instruction queue
package fetch_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ILEN_DEF = 32;

  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [ILEN_DEF-1:0] NOP_INSTR    = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush.
//   clk, rst           : clock, synchronous active-high reset (pointers only)
//   push, push_data    : write request and payload
//   pop, pop_data      : read request and current head (first-word fall-through)
//   flush              : drop all entries this cycle
//   full, empty, count : occupancy status
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module fetch_fifo #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = CW'(wr_ptr - rd_ptr);

  // A pop frees the head slot in the same cycle, so push while full is fine
  // when it is paired with a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage with an instruction queue and multiple outstanding cache requests.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   bellek_istek_o/ps_o   : fetch request valid / address (current PC)
//   bellek_hazir_i        : cache accepts the request this cycle
//   bellek_gecerli_i/deger_i : in-order response valid / instruction word
//   coz_buyruk_o/ps_o     : queue head instruction / its PC
//   coz_buyruk_gecerli_o  : queue head valid
//   coz_bos_i             : decode ready (pop = valid & ready)
//   yurut_ps_i            : branch target
//   yurut_ps_gecerli_i    : branch resolved
//   yurut_atladi_i        : branch taken (redirect = resolved & taken)
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN            = XLEN_DEF,
  parameter int              ILEN            = ILEN_DEF,
  parameter int              QUEUE_DEPTH     = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            bellek_istek_o,
  output logic [XLEN-1:0] bellek_ps_o,
  input  logic            bellek_hazir_i,
  input  logic            bellek_gecerli_i,
  input  logic [ILEN-1:0] bellek_deger_i,
  output logic [ILEN-1:0] coz_buyruk_o,
  output logic [XLEN-1:0] coz_ps_o,
  output logic            coz_buyruk_gecerli_o,
  input  logic            coz_bos_i,
  input  logic [XLEN-1:0] yurut_ps_i,
  input  logic            yurut_ps_gecerli_i,
  input  logic            yurut_atladi_i
);

  localparam int OW        = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW        = $clog2(QUEUE_DEPTH + 1);
  localparam int TAG_DEPTH = (MAX_OUTSTANDING < 2) ? 2 : (1 << $clog2(MAX_OUTSTANDING));
  localparam int TW        = $clog2(TAG_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc;
  logic [OW-1:0]   pending;
  logic [OW-1:0]   discard;

  logic            redirect;
  logic            credit_ok;
  logic            room_ok;
  logic            accept;
  logic            resp;
  logic            resp_live;
  logic            q_pop;

  logic [XLEN-1:0] tag_head;
  logic            tag_full;
  logic            tag_empty;
  logic [TW-1:0]   tag_count;

  entry_t          q_head;
  logic            q_full;
  logic            q_empty;
  logic [QW-1:0]   q_count;

  assign redirect = yurut_ps_gecerli_i & yurut_atladi_i;

  // Credit rule: in-flight (live + doomed) requests bounded by MAX_OUTSTANDING,
  // and queue space is reserved for every live request, so the queue cannot overflow.
  assign credit_ok = (int'(pending) + int'(discard)) < MAX_OUTSTANDING;
  assign room_ok   = (int'(q_count) + int'(pending)) < QUEUE_DEPTH;

  assign bellek_istek_o = ~rst_i & ~redirect & credit_ok & room_ok;
  assign bellek_ps_o    = pc;
  assign accept         = bellek_istek_o & bellek_hazir_i;

  // Responses with nothing outstanding are ignored (pre-reset leftovers).
  assign resp      = ~rst_i & bellek_gecerli_i & ((pending != '0) | (discard != '0));
  // Only the oldest doomed responses are dropped; after those, responses are live.
  assign resp_live = resp & ~redirect & (discard == '0);

  assign coz_buyruk_gecerli_o = ~rst_i & ~redirect & ~q_empty;
  assign coz_buyruk_o         = rst_i ? '0 : q_head.instr;
  assign coz_ps_o             = rst_i ? '0 : q_head.pc;
  assign q_pop                = coz_buyruk_gecerli_o & coz_bos_i;

  // Issue / response bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc      <= RESET_PC;
      pending <= '0;
      discard <= '0;
    end else if (redirect) begin
      // Everything still in flight becomes doomed; a response arriving now
      // retires one of them immediately.
      pc      <= yurut_ps_i;
      pending <= '0;
      discard <= discard + pending - OW'(resp);
    end else begin
      if (accept) pc <= pc + XLEN'(4);
      pending <= pending + OW'(accept) - OW'(resp_live);
      discard <= discard - OW'(resp & (discard != '0));
    end
  end

  // In-flight PC tags, consumed in order as live responses return
  fetch_fifo #(
    .DATA_W (XLEN),
    .DEPTH  (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (accept),
    .push_data (pc),
    .pop       (resp_live),
    .pop_data  (tag_head),
    .flush     (redirect),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  // Instruction queue toward decode
  fetch_fifo #(
    .DATA_W ($bits(entry_t)),
    .DEPTH  (QUEUE_DEPTH)
  ) u_instr_queue (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (resp_live),
    .push_data ({tag_head, bellek_deger_i}),
    .pop       (q_pop),
    .pop_data  (q_head),
    .flush     (redirect),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  tag_sync_chk: assert property (@(posedge clk_i) disable iff (rst_i)
    int'(tag_count) == int'(pending));
  tag_ovf_chk: assert property (@(posedge clk_i) disable iff (rst_i)
    !(accept && tag_full));
  tag_udf_chk: assert property (@(posedge clk_i) disable iff (rst_i)
    !(resp_live && tag_empty));
  q_ovf_chk: assert property (@(posedge clk_i) disable iff (rst_i)
    !(resp_live && q_full && !q_pop));

endmodule

// File: tb/tb_fetch_queue_stage.sv
module tb_fetch_queue_stage;
  import fetch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        bellek_istek_o;
  logic [31:0] bellek_ps_o;
  logic        bellek_hazir_i;
  logic        bellek_gecerli_i;
  logic [31:0] bellek_deger_i;
  logic [31:0] coz_buyruk_o;
  logic [31:0] coz_ps_o;
  logic        coz_buyruk_gecerli_o;
  logic        coz_bos_i;
  logic [31:0] yurut_ps_i;
  logic        yurut_ps_gecerli_i;
  logic        yurut_atladi_i;

  always #5 clk_i = ~clk_i;

  fetch_queue_stage dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .bellek_istek_o       (bellek_istek_o),
    .bellek_ps_o          (bellek_ps_o),
    .bellek_hazir_i       (bellek_hazir_i),
    .bellek_gecerli_i     (bellek_gecerli_i),
    .bellek_deger_i       (bellek_deger_i),
    .coz_buyruk_o         (coz_buyruk_o),
    .coz_ps_o             (coz_ps_o),
    .coz_buyruk_gecerli_o (coz_buyruk_gecerli_o),
    .coz_bos_i            (coz_bos_i),
    .yurut_ps_i           (yurut_ps_i),
    .yurut_ps_gecerli_i   (yurut_ps_gecerli_i),
    .yurut_atladi_i       (yurut_atladi_i)
  );

  typedef struct {
    logic [31:0] pc;
    int          due;
  } flight_t;

  typedef struct {
    logic        bos;
    logic        e_istek;
    logic [31:0] e_ps;
    logic        e_gv;
    logic [31:0] e_cps;
  } vec_t;

  flight_t      cache_q[$];
  fetch_entry_t sb[$];
  vec_t         tbl[11];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat_extra = 0;
  bit rand_lat  = 1'b0;

  logic        s_istek, s_gv;
  logic [31:0] s_ps, s_cps, s_cbuy;
  bit          resp_drv;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ NOP_INSTR;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive the cache response for this cycle, then sample the outputs.
  task automatic prep();
    resp_drv         = 1'b0;
    bellek_gecerli_i = 1'b0;
    bellek_deger_i   = '0;
    if (!rst_i && cache_q.size() > 0 && cache_q[0].due <= cyc) begin
      bellek_gecerli_i = 1'b1;
      bellek_deger_i   = word_of(cache_q[0].pc);
      resp_drv         = 1'b1;
    end
    #1;
    s_istek = bellek_istek_o;
    s_ps    = bellek_ps_o;
    s_gv    = coz_buyruk_gecerli_o;
    s_cps   = coz_ps_o;
    s_cbuy  = coz_buyruk_o;
  endtask

  // Scoreboard / cache model update for the coming edge, then advance.
  task automatic fin();
    fetch_entry_t e;
    int lat;
    if (rst_i) begin
      sb.delete();
      cache_q.delete();
    end else begin
      if (s_gv && coz_bos_i) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got pc %h want no entry (cycle %0d)", s_cps, cyc);
        end else begin
          e = sb.pop_front();
          chk("sb_pc", s_cps, e.pc);
          chk("sb_word", s_cbuy, e.instr);
        end
      end
      if (resp_drv) cache_q.delete(0);
      if (s_istek && bellek_hazir_i) begin
        lat = rand_lat ? int'($urandom_range(0, 2)) : lat_extra;
        cache_q.push_back('{pc: s_ps, due: cyc + 1 + lat});
        e.pc    = s_ps;
        e.instr = word_of(s_ps);
        sb.push_back(e);
      end
      if (yurut_ps_gecerli_i && yurut_atladi_i) sb.delete();
    end
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic no_branch();
    yurut_ps_i         = '0;
    yurut_ps_gecerli_i = 1'b0;
    yurut_atladi_i     = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    no_branch();
    prep();
    chk("rst_istek", {31'd0, s_istek}, 32'd0);
    chk("rst_gv", {31'd0, s_gv}, 32'd0);
    chk("rst_buyruk", s_cbuy, 32'd0);
    chk("rst_cps", s_cps, 32'd0);
    fin();
    rst_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_i = 1'b1; bellek_hazir_i = 1'b1; bellek_gecerli_i = 1'b0;
    bellek_deger_i = '0; coz_bos_i = 1'b0; no_branch();

    // bos, istek, ps, gecerli, coz_ps
    tbl[0]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 32'd4,  1'b0, 32'd0};
    tbl[2]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd0};
    tbl[3]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd0};
    tbl[4]  = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
    tbl[5]  = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
    tbl[6]  = '{1'b1, 1'b0, 32'd16, 1'b1, 32'd0};
    tbl[7]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd4};
    tbl[8]  = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd8};
    tbl[9]  = '{1'b1, 1'b1, 32'd24, 1'b1, 32'd12};
    tbl[10] = '{1'b1, 1'b1, 32'd28, 1'b1, 32'd16};

    @(negedge clk_i);

    // Basic streaming
    coz_bos_i = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      prep();
      if (i < 3) chk("t1_ps", s_ps, 32'(i * 4));
      if (i < 2) chk("t1_gv_lat", {31'd0, s_gv}, 32'd0);
      else       chk("t1_cps", s_gv ? s_cps : 32'hDEAD_BEEF, 32'((i - 2) * 4));
      fin();
    end
    for (int i = 0; i < 5; i++) begin prep(); fin(); end

    // Fill with decode stalled, then release
    coz_bos_i = 1'b0;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      coz_bos_i = tbl[i].bos;
      prep();
      chk("t2_istek", {31'd0, s_istek}, {31'd0, tbl[i].e_istek});
      chk("t2_ps", s_ps, tbl[i].e_ps);
      chk("t2_gv", {31'd0, s_gv}, {31'd0, tbl[i].e_gv});
      if (tbl[i].e_gv) chk("t2_cps", s_cps, tbl[i].e_cps);
      fin();
    end
    for (int i = 0; i < 6; i++) begin prep(); fin(); end

    // Redirect with two requests in flight
    coz_bos_i = 1'b1; lat_extra = 3;
    do_reset();
    prep(); fin();
    prep(); fin();
    yurut_ps_i = 32'h100; yurut_ps_gecerli_i = 1'b1; yurut_atladi_i = 1'b1;
    prep();
    chk("t3_redir_istek", {31'd0, s_istek}, 32'd0);
    chk("t3_redir_gv", {31'd0, s_gv}, 32'd0);
    fin();
    no_branch();
    prep();
    chk("t3_ps_target", s_ps, 32'h100);
    fin();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      prep();
      if (s_gv) begin
        chk("t3_first_cps", s_cps, 32'h100);
        seen = 1'b1;
      end
      fin();
    end
    if (!seen) begin total++; bad++; $display("FAIL t3_timeout: got no valid want coz_ps 100"); end
    lat_extra = 0;

    // Response and redirect in the same cycle, two entries queued
    coz_bos_i = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin prep(); fin(); end
    yurut_ps_i = 32'h200; yurut_ps_gecerli_i = 1'b1; yurut_atladi_i = 1'b1;
    prep();
    chk("t4_resp_present", {31'd0, resp_drv}, 32'd1);
    chk("t4_redir_gv", {31'd0, s_gv}, 32'd0);
    chk("t4_redir_istek", {31'd0, s_istek}, 32'd0);
    fin();
    no_branch();
    prep();
    chk("t4_istek", {31'd0, s_istek}, 32'd1);
    chk("t4_ps", s_ps, 32'h200);
    chk("t4_empty", {31'd0, s_gv}, 32'd0);
    fin();
    coz_bos_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      prep();
      if (s_gv) begin
        chk("t4_first_cps", s_cps, 32'h200);
        seen = 1'b1;
      end
      fin();
    end
    if (!seen) begin total++; bad++; $display("FAIL t4_timeout: got no valid want coz_ps 200"); end

    // Cache stall and not-taken branch
    coz_bos_i = 1'b1; bellek_hazir_i = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      prep();
      chk("t5_stall_istek", {31'd0, s_istek}, 32'd1);
      chk("t5_stall_ps", s_ps, 32'd0);
      fin();
    end
    bellek_hazir_i = 1'b1;
    prep(); chk("t5_ps0", s_ps, 32'd0); fin();
    yurut_ps_i = 32'h300; yurut_ps_gecerli_i = 1'b1; yurut_atladi_i = 1'b0;
    prep(); chk("t5_nt_ps", s_ps, 32'd4); chk("t5_nt_istek", {31'd0, s_istek}, 32'd1); fin();
    no_branch();
    prep(); chk("t5_after_ps", s_ps, 32'd8); fin();
    for (int i = 0; i < 6; i++) begin prep(); fin(); end

    // Mid-stream reset with three queued
    coz_bos_i = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin prep(); fin(); end
    rst_i = 1'b1;
    prep();
    chk("t6_rst_gv", {31'd0, s_gv}, 32'd0);
    chk("t6_rst_istek", {31'd0, s_istek}, 32'd0);
    fin();
    rst_i = 1'b0;
    prep();
    chk("t6_gv", {31'd0, s_gv}, 32'd0);
    chk("t6_istek", {31'd0, s_istek}, 32'd1);
    chk("t6_ps", s_ps, RESET_PC_DEF);
    fin();
    coz_bos_i = 1'b1;
    for (int i = 0; i < 10; i++) begin prep(); fin(); end

    // Random soak
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst_i          = ($urandom_range(0, 299) == 0);
      bellek_hazir_i = ($urandom_range(0, 3) != 0);
      coz_bos_i      = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) begin
        yurut_ps_i         = $urandom;
        yurut_ps_gecerli_i = 1'b1;
        yurut_atladi_i     = $urandom_range(0, 1) != 0;
      end else begin
        no_branch();
      end
      prep(); fin();
    end
    rst_i = 1'b0; no_branch(); bellek_hazir_i = 1'b0; coz_bos_i = 1'b1;
    for (int i = 0; i < 60 && (sb.size() > 0 || cache_q.size() > 0); i++) begin
      prep(); fin();
    end
    chk("soak_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
